// File: rtl/add64_pkg.sv
// add64_pkg: shared types and constants for the 64-bit adder I/O sequencer.
//   state_t        - sequencer FSM states
//   BEAT_*         - input beat index of each operand half
//   DEF_DATA_W/BUS - default operand and bus widths
package add64_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_BUS_W  = DEF_DATA_W / 2;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        SETTLE  = 2'd1,
        SEND_LO = 2'd2,
        SEND_HI = 2'd3
    } state_t;

    localparam logic [1:0] BEAT_A_LO = 2'd0;
    localparam logic [1:0] BEAT_A_HI = 2'd1;
    localparam logic [1:0] BEAT_B_LO = 2'd2;
    localparam logic [1:0] BEAT_B_HI = 2'd3;

endpackage

// File: rtl/add64_settle_timer.sv
// add64_settle_timer: counts adder propagation cycles while the sequencer
// sits in SETTLE and flags the cycle on which the sum may be captured.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   run_i  - high while waiting for the adder to settle
//   done_o - high in the cycle whose closing edge should capture the sum
module add64_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic done_o
);

    localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);

    logic [3:0] settle_cnt;

    assign done_o = run_i && (settle_cnt == LAST);

    // Counter rests at zero outside SETTLE so every operation starts fresh.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            settle_cnt <= '0;
        end else if (!run_i || done_o) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/add64_io_sequencer.sv
// add64_io_sequencer: streams two 64-bit operands in as four 32-bit beats
// (A_lo, A_hi, B_lo, B_hi), presents them to an external adder, waits
// SETTLE_CYC cycles, captures the sum and streams it out as S_lo, S_hi.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   in_valid_i/in_ready_o - input beat handshake, in_data_i beat
//   out_valid_o/out_ready_i - output beat handshake, out_data_o beat
//   num1_o, num2_o        - registered operands to the adder
//   sum_i                 - adder result
//   busy_o                - an operation is in progress
module add64_io_sequencer
    import add64_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BUS_W      = DATA_W / 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [BUS_W-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [BUS_W-1:0]  out_data_o,
    output logic [DATA_W-1:0] num1_o,
    output logic [DATA_W-1:0] num2_o,
    input  logic [DATA_W-1:0] sum_i,
    output logic              busy_o
);

    state_t             state_q, state_d;
    logic [1:0]         beat_cnt;
    logic [DATA_W-1:0]  result_q;
    logic               in_xfer;
    logic               settle_done;

    assign in_xfer = in_valid_i && in_ready_o;

    add64_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run_i  (state_q == SETTLE),
        .done_o (settle_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs depend on state only, never on the partner's signal.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        case (state_q)
            LOAD: begin
                in_ready_o = 1'b1;
                if (in_xfer && beat_cnt == BEAT_B_HI) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                out_valid_o = 1'b1;
                out_data_o  = result_q[BUS_W-1:0];
                if (out_ready_i) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                out_valid_o = 1'b1;
                out_data_o  = result_q[DATA_W-1:BUS_W];
                if (out_ready_i) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign busy_o = (state_q != LOAD) || (beat_cnt != 2'd0);

    // Operand assembly; registers keep their values after the operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt <= 2'd0;
            num1_o   <= '0;
            num2_o   <= '0;
        end else if (in_xfer) begin
            case (beat_cnt)
                BEAT_A_LO: num1_o[BUS_W-1:0]      <= in_data_i;
                BEAT_A_HI: num1_o[DATA_W-1:BUS_W] <= in_data_i;
                BEAT_B_LO: num2_o[BUS_W-1:0]      <= in_data_i;
                default:   num2_o[DATA_W-1:BUS_W] <= in_data_i;
            endcase
            beat_cnt <= (beat_cnt == BEAT_B_HI) ? 2'd0 : beat_cnt + 2'd1;
        end
    end

    // sum_i is looked at only on the capture edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else if (state_q == SETTLE && settle_done) begin
            result_q <= sum_i;
        end
    end

endmodule
